// File: rtl/apu_frame_rx.sv
// 8N1 UART receiver for the APU command link: recovers bytes, packs four into a frame, stretches link activity.
// Build option: APU_FRAME_TIMEOUT_EN drops a stalled partial frame after IDLE_BITS bit periods of idle line.
//
// state | meaning
// IDLE  | waiting for rxs low
// START | counting to mid start bit, confirm it is still low
// DATA  | sampling eight data bits, LSB first, at mid-bit
// STOP  | sampling stop bit; 1 = good byte, 0 = framing error
module apu_frame_rx #(
  parameter int CLKRATE   = 1_789_773,
  parameter int BAUDRATE  = 9600,
  parameter int LINK_BITS = 16,
  parameter int IDLE_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [31:0] frame_data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        link
);

  localparam int DIV  = CLKRATE / BAUDRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bitn_q, bitn_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_ok, bad_stop;
  logic            sync1, rxs;
  logic [1:0]      fcnt_q;
  logic [31:0]     lanes_q;
  logic [LINK_BITS-1:0] link_cnt_q;
  logic            to_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitn_d   = bitn_q;
    shift_d  = shift_q;
    byte_ok  = 1'b0;
    bad_stop = 1'b0;
    if (state_q != IDLE) cnt_d = cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          cnt_d   = HALF_M1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rxs) begin
            cnt_d   = DIV_M1;
            bitn_d  = 3'd0;
            state_d = DATA;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = DIV_M1;
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs) byte_ok  = 1'b1;
          else     bad_stop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef APU_FRAME_TIMEOUT_EN
  localparam int TO = IDLE_BITS * DIV;
  localparam int TW = $clog2(TO + 1);
  logic [TW-1:0] idle_q;

  assign to_hit = (state_q == IDLE) && (fcnt_q != 2'd0) && (idle_q == '0);

  // Down-counter only runs while a partial frame waits on an idle line.
  always_ff @(posedge clk) begin
    if (reset || state_q != IDLE || fcnt_q == 2'd0 || idle_q == '0)
      idle_q <= TW'(TO - 1);
    else
      idle_q <= idle_q - 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      fcnt_q      <= '0;
      lanes_q     <= '0;
    end else begin
      byte_valid  <= byte_ok;
      frame_err   <= bad_stop;
      frame_valid <= 1'b0;
      if (byte_ok) begin
        byte_data <= shift_q;
        lanes_q[{fcnt_q, 3'b000} +: 8] <= shift_q;
        fcnt_q <= fcnt_q + 2'd1;
        if (fcnt_q == 2'd3) begin
          frame_data  <= {shift_q, lanes_q[23:0]};
          frame_valid <= 1'b1;
        end
      end else if (bad_stop || to_hit) begin
        fcnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      link_cnt_q <= '0;
    else if (byte_ok)
      link_cnt_q <= '1;
    else if (link_cnt_q != '0)
      link_cnt_q <= link_cnt_q - 1'b1;
  end

  assign link = (link_cnt_q != '0);

endmodule

// File: tb/tb_apu_frame_rx.sv
// Directed bench for apu_frame_rx: byte/frame scoreboard queues checked by a negedge monitor.
module tb_apu_frame_rx;
  localparam int DIV = 186;

  logic        clk = 1'b0;
  logic        reset, rx;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [31:0] frame_data;
  logic        frame_valid, frame_err, link;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_frames[$];

  always #5 clk = ~clk;

  apu_frame_rx #(.LINK_BITS(8)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_err(frame_err), .link(link)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    if (good) begin
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (DIV / 2 + 30) @(negedge clk);
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_bytes_left"}, exp_bytes.size(), 32'd0);
    chk({tag, "_frames_left"}, exp_frames.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid) begin
        if (exp_bytes.size() == 0) chk("unexpected_byte", {31'd0, byte_valid}, 32'd0);
        else chk("byte_data", {24'd0, byte_data}, {24'd0, exp_bytes.pop_front()});
        chk("byte_err_excl", {31'd0, frame_err}, 32'd0);
      end
      if (frame_err) err_cnt++;
      if (frame_valid) begin
        chk("frame_with_byte", {31'd0, byte_valid}, 32'd1);
        if (exp_frames.size() == 0) chk("unexpected_frame", {31'd0, frame_valid}, 32'd0);
        else chk("frame_data", frame_data, exp_frames.pop_front());
      end
    end
  end

  initial begin
    rx = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // idle line after reset
    repeat (1000) @(negedge clk);
    chk("idle_byte_data", {24'd0, byte_data}, 32'd0);
    chk("idle_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("idle_frame_data", frame_data, 32'd0);
    chk("idle_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("idle_frame_err", {31'd0, frame_err}, 32'd0);
    chk("idle_link", {31'd0, link}, 32'd0);

    // back-to-back frame
    exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h23);
    exp_bytes.push_back(8'h45); exp_bytes.push_back(8'h67);
    exp_frames.push_back(32'h6745_2301);
    send_byte(8'h01, 1'b1); send_byte(8'h23, 1'b1);
    send_byte(8'h45, 1'b1); send_byte(8'h67, 1'b1);
    chk("link_on", {31'd0, link}, 32'd1);
    drain("frame1");
    repeat (300) @(negedge clk);
    chk("link_expired", {31'd0, link}, 32'd0);

    // short glitch is a false start
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_err_cnt", err_cnt, 32'd0);
    drain("glitch");

    // framing error clears the partial frame
    exp_bytes.push_back(8'h99);
    send_byte(8'h99, 1'b1);
    send_byte(8'h55, 1'b0);
    exp_bytes.push_back(8'hAA); exp_bytes.push_back(8'hBB);
    exp_bytes.push_back(8'hCC); exp_bytes.push_back(8'hDD);
    exp_frames.push_back(32'hDDCC_BBAA);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
    drain("frame_err");
    chk("err_cnt_after_bad_stop", err_cnt, 32'd1);

    // reset in the middle of the third byte
    exp_bytes.push_back(8'h21); exp_bytes.push_back(8'h22);
    send_byte(8'h21, 1'b1); send_byte(8'h22, 1'b1);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (DIV / 2) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_byte_data", {24'd0, byte_data}, 32'd0);
    chk("rst_frame_data", frame_data, 32'd0);
    chk("rst_link", {31'd0, link}, 32'd0);
    repeat (10) @(negedge clk);
    exp_bytes.push_back(8'h10); exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h13);
    exp_frames.push_back(32'h1312_1110);
    send_byte(8'h10, 1'b1); send_byte(8'h11, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h13, 1'b1);
    drain("after_reset");
    chk("err_cnt_after_reset", err_cnt, 32'd1);

    // one byte, long idle, then four bytes
    exp_bytes.push_back(8'h77);
    send_byte(8'h77, 1'b1);
    repeat (20 * DIV + 10) @(negedge clk);
    exp_bytes.push_back(8'h10); exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h13);
`ifdef APU_FRAME_TIMEOUT_EN
    exp_frames.push_back(32'h1312_1110);
`else
    exp_frames.push_back(32'h1211_1077);
`endif
    send_byte(8'h10, 1'b1); send_byte(8'h11, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h13, 1'b1);
    drain("timeout");
    chk("err_cnt_final", err_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
